// File: rtl/md_pkg.sv
// Shared encodings and default timing for the multiply/divide sequencer.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_scheduler_if.sv
// E-stage <-> MD unit signal bundle; master is pipeline control, slave is the sequencer.
interface md_scheduler_if;
  import md_pkg::*;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b, md_use_d,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b, md_use_d,
    output busy, stall_md, hi, lo
  );

endinterface

// File: rtl/md_arith.sv
// Combinational mult/div datapath producing {hi,lo}; signed division works on
// magnitudes so 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
module md_arith
  import md_pkg::*;
(
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic [2:0]  md_op_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic [63:0] prodSigned;
  logic [63:0] prodUnsigned;
  logic        signedDiv;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] divisor;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prodSigned   = {{32{src_a_i[31]}}, src_a_i} * {{32{src_b_i[31]}}, src_b_i};
    prodUnsigned = {32'd0, src_a_i} * {32'd0, src_b_i};

    signedDiv = (md_op_i == MD_DIV);
    magA      = (signedDiv && src_a_i[31]) ? -src_a_i : src_a_i;
    magB      = (signedDiv && src_b_i[31]) ? -src_b_i : src_b_i;
    // Zero divisor is replaced so the datapath stays defined; the result is discarded anyway.
    divisor   = (magB == 32'd0) ? 32'd1 : magB;
    quot      = magA / divisor;
    rem       = magA % divisor;
    if (signedDiv && (src_a_i[31] ^ src_b_i[31])) quot = -quot;
    if (signedDiv && src_a_i[31]) rem = -rem;

    div_by_zero_o = (src_b_i == 32'd0) &&
                    ((md_op_i == MD_DIV) || (md_op_i == MD_DIVU));

    case (md_op_i)
      MD_MULT:         result_o = prodSigned;
      MD_MULTU:        result_o = prodUnsigned;
      MD_DIV, MD_DIVU: result_o = {rem, quot};
      default:         result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer: owns HI/LO, models fixed latency with a busy
// counter and raises the D-stage stall for HI/LO users while occupied.
module md_scheduler
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  md_scheduler_if.slave  mdIf
);

  md_state_e   state_q,     state_d;
  logic [3:0]  count_q,     count_d;
  logic [31:0] hi_q,        hi_d;
  logic [31:0] lo_q,        lo_d;
  logic [31:0] pendHi_q,    pendHi_d;
  logic [31:0] pendLo_q,    pendLo_d;
  logic        pendWrite_q, pendWrite_d;

  logic [63:0] arithResult;
  logic        divByZero;

  md_arith uArith (
    .src_a_i       (mdIf.src_a),
    .src_b_i       (mdIf.src_b),
    .md_op_i       (mdIf.md_op),
    .result_o      (arithResult),
    .div_by_zero_o (divByZero)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pendHi_d    = pendHi_q;
    pendLo_d    = pendLo_q;
    pendWrite_d = pendWrite_q;

    case (state_q)
      ST_IDLE: begin
        if (mdIf.start) begin
          case (mdIf.md_op)
            MD_MULT, MD_MULTU: begin
              pendHi_d    = arithResult[63:32];
              pendLo_d    = arithResult[31:0];
              pendWrite_d = 1'b1;
              count_d     = 4'(MULT_CYCLES);
              state_d     = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pendHi_d    = arithResult[63:32];
              pendLo_d    = arithResult[31:0];
              pendWrite_d = !divByZero;
              count_d     = 4'(DIV_CYCLES);
              state_d     = ST_BUSY;
            end
            MD_MTHI: hi_d = mdIf.src_a;
            MD_MTLO: lo_d = mdIf.src_a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // start is deliberately ignored here; stall_md keeps legal code from issuing.
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          if (pendWrite_q) begin
            hi_d = pendHi_q;
            lo_d = pendLo_q;
          end
          count_d = 4'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= 4'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pendHi_q    <= 32'd0;
      pendLo_q    <= 32'd0;
      pendWrite_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pendHi_q    <= pendHi_d;
      pendLo_q    <= pendLo_d;
      pendWrite_q <= pendWrite_d;
    end
  end

  assign mdIf.busy     = (state_q == ST_BUSY);
  assign mdIf.stall_md = mdIf.md_use_d & (mdIf.start | mdIf.busy);
  assign mdIf.hi       = hi_q;
  assign mdIf.lo       = lo_q;

endmodule
